// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-side memory stage.
// Holds the funct3 size codes, the MMIO register offsets, and the STATUS bit indices.
// It also provides the store byte-lane helpers used by riscv_dmem_io.
package riscv_mem_pkg;

  // funct3 access-size codes as driven by the core's M stage
  localparam logic [2:0] SizeB  = 3'b000;
  localparam logic [2:0] SizeH  = 3'b001;
  localparam logic [2:0] SizeW  = 3'b010;
  localparam logic [2:0] SizeBu = 3'b100;
  localparam logic [2:0] SizeHu = 3'b101;

  // Byte offsets inside the 16-byte MMIO window
  localparam logic [3:0] OffTx     = 4'h0;
  localparam logic [3:0] OffCycle  = 4'h4;
  localparam logic [3:0] OffStatus = 4'h8;

  // STATUS register bit positions
  localparam int unsigned StEmpty    = 0;
  localparam int unsigned StFull     = 1;
  localparam int unsigned StMisalign = 2;
  localparam int unsigned StOverflow = 3;

  // True when a store of this size may legally target this byte offset.
  // Size codes that are not store sizes are never aligned.
  function automatic logic store_aligned(input logic [2:0] size, input logic [1:0] lo);
    case (size)
      SizeB:   store_aligned = 1'b1;
      SizeH:   store_aligned = ~lo[0];
      SizeW:   store_aligned = (lo == 2'b00);
      default: store_aligned = 1'b0;
    endcase
  endfunction

  // Byte enables for an aligned store
  function automatic logic [3:0] store_lanes(input logic [2:0] size, input logic [1:0] lo);
    case (size)
      SizeB:   store_lanes = 4'b0001 << lo;
      SizeH:   store_lanes = lo[1] ? 4'b1100 : 4'b0011;
      SizeW:   store_lanes = 4'b1111;
      default: store_lanes = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with registered storage.
// The head entry is presented combinationally from storage.
// Ports:
//   clk_i, reset_i : clock and asynchronous active-high reset
//   push_i, data_i : enqueue request and byte
//   pop_i          : dequeue request; it is ignored while the FIFO is empty
//   full_o, empty_o, count_o : occupancy
//   head_o         : oldest byte (0 after reset)
//   drop_o         : a push was refused because the FIFO was full and nothing popped
module byte_fifo #(
  parameter int unsigned Depth = 8,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            push_i,
  input  logic [7:0]      data_i,
  input  logic            pop_i,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o,
  output logic [7:0]      head_o,
  output logic            drop_o
);

  logic [7:0]      mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            pop_ok, push_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a full FIFO still accepts push+pop
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign drop_o  = push_i && full_o && !pop_ok;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push_ok && !pop_ok)      count_q <= count_q + CntW'(1);
      else if (pop_ok && !push_ok) count_q <= count_q - CntW'(1);
    end
  end

endmodule

// File: rtl/riscv_dmem_io.sv
// Data memory stage: byte-addressable word RAM plus a 16-byte MMIO window.
// The window holds a TX byte FIFO, a free-running cycle counter and a STATUS/sticky-error register.
// Ports:
//   clk, reset        : clock and asynchronous active-high reset
//   memwrite, memsize : store strobe and funct3 size code from the M stage
//   addr, wdata       : byte address and store data
//   rdata             : combinational load data
//   tx_valid, tx_data, tx_ready : FIFO drain handshake
//   err_irq           : registered OR of the sticky error bits
module riscv_dmem_io
  import riscv_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FFF0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [2:0]  memsize,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        err_irq
);

  localparam int unsigned AddrW = $clog2(MEM_WORDS);
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]      mem_q [MEM_WORDS];
  logic [AddrW-1:0] word_idx;
  logic             in_ram, in_mmio;
  logic             ram_aligned, mmio_word;
  logic             ram_store, mmio_store, misalign_evt;
  logic             tx_push, cycle_wr, status_wr;
  logic [3:0]       ram_be;
  logic [31:0]      ram_wdata;

  logic [31:0]      cycle_q, cycle_d;
  logic             misalign_q, misalign_d;
  logic             overflow_q, overflow_d;

  logic             fifo_full, fifo_empty, fifo_drop;
  logic [CntW-1:0]  fifo_count;
  logic [31:0]      status_word;

  logic [31:0]      ram_word;
  logic [7:0]       ram_byte;
  logic [15:0]      ram_half;

  // ---------------- address decode ----------------
  assign word_idx = addr[AddrW+1:2];
  assign in_ram   = ((addr >> (AddrW + 2)) == 32'd0);
  assign in_mmio  = (addr[31:4] == MMIO_BASE[31:4]);

  assign ram_aligned = store_aligned(memsize, addr[1:0]);
  // MMIO registers only take aligned word writes
  assign mmio_word   = (memsize == SizeW) && (addr[1:0] == 2'b00);

  assign ram_store    = memwrite && in_ram && ram_aligned;
  assign mmio_store   = memwrite && in_mmio && mmio_word;
  // Stores that miss both RAM and MMIO are silently dropped, not flagged
  assign misalign_evt = memwrite && ((in_ram && !ram_aligned) || (in_mmio && !mmio_word));

  assign tx_push   = mmio_store && (addr[3:0] == OffTx);
  assign cycle_wr  = mmio_store && (addr[3:0] == OffCycle);
  assign status_wr = mmio_store && (addr[3:0] == OffStatus);

  // ---------------- RAM ----------------
  assign ram_be = store_lanes(memsize, addr[1:0]);

  // Replicate the low bits of wdata so every enabled lane sees the right byte
  always_comb begin
    case (memsize)
      SizeB:   ram_wdata = {4{wdata[7:0]}};
      SizeH:   ram_wdata = {2{wdata[15:0]}};
      default: ram_wdata = wdata;
    endcase
  end

  // RAM contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (ram_store) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_be[b]) mem_q[word_idx][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
  end

  // ---------------- TX FIFO ----------------
  byte_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (tx_push),
    .data_i  (wdata[7:0]),
    .pop_i   (tx_ready),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  (tx_data),
    .drop_o  (fifo_drop)
  );

  assign tx_valid = !fifo_empty;

  // ---------------- counter and sticky bits ----------------
  always_comb begin
    cycle_d = cycle_wr ? wdata : cycle_q + 32'd1;

    // A set event in the same cycle as a write-1-to-clear wins
    misalign_d = misalign_q;
    if (status_wr && wdata[StMisalign]) misalign_d = 1'b0;
    if (misalign_evt)                   misalign_d = 1'b1;

    overflow_d = overflow_q;
    if (status_wr && wdata[StOverflow]) overflow_d = 1'b0;
    if (fifo_drop)                      overflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q    <= '0;
      misalign_q <= 1'b0;
      overflow_q <= 1'b0;
      err_irq    <= 1'b0;
    end else begin
      cycle_q    <= cycle_d;
      misalign_q <= misalign_d;
      overflow_q <= overflow_d;
      err_irq    <= misalign_q | overflow_q;
    end
  end

  assign status_word = {28'd0, overflow_q, misalign_q, fifo_full, fifo_empty};

  // ---------------- load path ----------------
  assign ram_word = mem_q[word_idx];
  assign ram_half = addr[1] ? ram_word[31:16] : ram_word[15:0];

  always_comb begin
    unique case (addr[1:0])
      2'd0: ram_byte = ram_word[7:0];
      2'd1: ram_byte = ram_word[15:8];
      2'd2: ram_byte = ram_word[23:16];
      2'd3: ram_byte = ram_word[31:24];
    endcase
  end

  always_comb begin
    rdata = '0;
    if (in_ram) begin
      case (memsize)
        SizeB:   rdata = {{24{ram_byte[7]}}, ram_byte};
        SizeBu:  rdata = {24'd0, ram_byte};
        SizeH:   rdata = {{16{ram_half[15]}}, ram_half};
        SizeHu:  rdata = {16'd0, ram_half};
        SizeW:   rdata = ram_word;
        default: rdata = '0;
      endcase
    end else if (in_mmio) begin
      case (addr[3:2])
        OffTx[3:2]:     rdata = 32'(fifo_count);
        OffCycle[3:2]:  rdata = cycle_q;
        OffStatus[3:2]: rdata = status_word;
        default:        rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_dmem_io.sv
// Self-checking bench for riscv_dmem_io: a table of RAM load/store vectors,
// followed by hand-written sequences for MMIO, FIFO, counter and reset corner cases.
module tb_riscv_dmem_io;
  import riscv_mem_pkg::*;

  localparam logic [31:0] TxA  = 32'hFFFF_FFF0;
  localparam logic [31:0] CycA = 32'hFFFF_FFF4;
  localparam logic [31:0] StA  = 32'hFFFF_FFF8;
  localparam logic [31:0] ResA = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [2:0]  memsize;
  logic [31:0] addr, wdata, rdata;
  logic        tx_valid, tx_ready, err_irq;
  logic [7:0]  tx_data;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        we;
    logic [2:0]  sz;
    logic [31:0] a;
    logic [31:0] val;   // store data, or expected load data
    string       name;
  } vec_t;

  vec_t vecs[$];

  riscv_dmem_io #(
    .MEM_WORDS  (1024),
    .FIFO_DEPTH (8),
    .MMIO_BASE  (32'hFFFF_FFF0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .memwrite (memwrite),
    .memsize  (memsize),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .err_irq  (err_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Store lands on the posedge; returns at posedge+1 with the strobe dropped
  task automatic store(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    memwrite = 1'b1;
    memsize  = sz;
    addr     = a;
    wdata    = d;
    @(posedge clk);
    #1;
    memwrite = 1'b0;
  endtask

  // Combinational load sampled just after a falling edge
  task automatic load(input logic [2:0] sz, input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    memwrite = 1'b0;
    memsize  = sz;
    addr     = a;
    #1;
    d = rdata;
  endtask

  task automatic add(input logic we, input logic [2:0] sz, input logic [31:0] a,
                     input logic [31:0] val, input string name);
    vec_t v;
    v.we = we; v.sz = sz; v.a = a; v.val = val; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] r;

    add(1'b1, SizeW,  32'h10,   32'h8081_82F3, "sw_10");
    add(1'b0, SizeB,  32'h10,   32'hFFFF_FFF3, "lb_10");
    add(1'b0, SizeBu, 32'h13,   32'h0000_0080, "lbu_13");
    add(1'b0, SizeH,  32'h12,   32'hFFFF_8081, "lh_12");
    add(1'b0, SizeHu, 32'h12,   32'h0000_8081, "lhu_12");
    add(1'b1, SizeB,  32'h11,   32'h0000_0055, "sb_11");
    add(1'b0, SizeW,  32'h10,   32'h8081_55F3, "lw_10_after_sb");
    add(1'b0, SizeB,  32'h11,   32'h0000_0055, "lb_11");
    add(1'b0, SizeHu, 32'h10,   32'h0000_55F3, "lhu_10");
    add(1'b1, SizeH,  32'h20,   32'hAAAA_BEEF, "sh_20");
    add(1'b1, SizeH,  32'h22,   32'h5555_1234, "sh_22");
    add(1'b0, SizeW,  32'h20,   32'h1234_BEEF, "lw_20");
    add(1'b0, SizeH,  32'h22,   32'h0000_1234, "lh_22");
    add(1'b0, SizeB,  32'h23,   32'h0000_0012, "lb_23");
    add(1'b0, SizeH,  32'h21,   32'hFFFF_BEEF, "lh_21_misaligned_read");
    add(1'b1, SizeW,  32'h0,    32'h1122_3344, "sw_0");
    add(1'b1, SizeW,  32'h1000, 32'hDEAD_BEEF, "sw_unmapped");
    add(1'b0, SizeW,  32'h0,    32'h1122_3344, "lw_0_no_alias");
    add(1'b0, SizeW,  32'h1000, 32'h0000_0000, "lw_1000_unmapped");
    add(1'b0, SizeW,  32'h2000, 32'h0000_0000, "lw_2000_unmapped");
    add(1'b0, SizeW,  ResA,     32'h0000_0000, "lw_mmio_reserved");
    add(1'b0, SizeW,  StA,      32'h0000_0001, "status_idle");
    add(1'b0, SizeW,  TxA,      32'h0000_0000, "tx_count_idle");

    // ---------------- reset ----------------
    reset    = 1'b1;
    memwrite = 1'b0;
    memsize  = SizeW;
    addr     = StA;
    wdata    = '0;
    tx_ready = 1'b0;
    #1;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data",  32'(tx_data),  32'd0);
    check("rst_err_irq",  32'(err_irq),  32'd0);
    check("rst_status",   rdata,         32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // ---------------- table ----------------
    foreach (vecs[i]) begin
      if (vecs[i].we) begin
        store(vecs[i].sz, vecs[i].a, vecs[i].val);
      end else begin
        load(vecs[i].sz, vecs[i].a, r);
        check(vecs[i].name, r, vecs[i].val);
      end
    end

    // ---------------- misaligned store ----------------
    store(SizeH, 32'h21, 32'h0000_7777);
    check("misal_irq_not_yet", 32'(err_irq), 32'd0);
    load(SizeW, StA, r);
    check("misal_status", r, 32'h5);
    @(posedge clk); #1;
    check("misal_irq", 32'(err_irq), 32'd1);
    load(SizeW, 32'h20, r);
    check("misal_ram_kept", r, 32'h1234_BEEF);
    store(SizeW, StA, 32'h4);
    load(SizeW, StA, r);
    check("misal_cleared", r, 32'h1);

    // Byte store to MMIO: misaligned, no push
    store(SizeB, TxA, 32'h99);
    load(SizeW, TxA, r);
    check("mmio_sb_no_push", r, 32'h0);
    load(SizeW, StA, r);
    check("mmio_sb_misal", r, 32'h5);
    store(SizeW, StA, 32'h4);

    // ---------------- overflow ----------------
    tx_ready = 1'b0;
    for (int i = 1; i <= 9; i++) store(SizeW, TxA, 32'(i));
    load(SizeW, TxA, r);
    check("ovf_count", r, 32'd8);
    load(SizeW, StA, r);
    check("ovf_status", r, 32'hA);
    check("ovf_head", 32'(tx_data), 32'h01);
    tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("drain_valid_%0d", i), 32'(tx_valid), 32'd1);
      check($sformatf("drain_data_%0d", i), 32'(tx_data), 32'(i));
      @(posedge clk); #1;
    end
    tx_ready = 1'b0;
    check("drain_empty", 32'(tx_valid), 32'd0);
    store(SizeW, StA, 32'h8);
    load(SizeW, StA, r);
    check("ovf_cleared", r, 32'h1);

    // ---------------- push+pop while full ----------------
    for (int i = 1; i <= 8; i++) store(SizeW, TxA, 32'(i));
    tx_ready = 1'b1;
    store(SizeW, TxA, 32'hAA);
    tx_ready = 1'b0;
    load(SizeW, TxA, r);
    check("pp_count", r, 32'd8);
    check("pp_head", 32'(tx_data), 32'h02);
    load(SizeW, StA, r);
    check("pp_status", r, 32'h2);
    tx_ready = 1'b1;
    for (int i = 2; i <= 9; i++) begin
      check($sformatf("pp_drain_%0d", i), 32'(tx_data), (i == 9) ? 32'hAA : 32'(i));
      @(posedge clk); #1;
    end
    tx_ready = 1'b0;
    check("pp_empty", 32'(tx_valid), 32'd0);

    // ---------------- cycle counter wrap ----------------
    store(SizeW, CycA, 32'hFFFF_FFFE);
    load(SizeW, CycA, r);
    check("cyc_loaded", r, 32'hFFFF_FFFE);
    @(posedge clk);
    @(posedge clk);
    load(SizeW, CycA, r);
    check("cyc_wrap", r, 32'h0000_0000);

    // ---------------- asynchronous reset mid-operation ----------------
    for (int i = 1; i <= 3; i++) store(SizeW, TxA, 32'(8'h11 * i));
    load(SizeW, TxA, r);
    check("pre_rst_count", r, 32'd3);
    @(negedge clk);
    memwrite = 1'b1;
    memsize  = SizeW;
    addr     = TxA;
    wdata    = 32'h44;
    #1;
    reset = 1'b1;
    #1;
    check("arst_tx_valid", 32'(tx_valid), 32'd0);
    memwrite = 1'b0;
    #1;
    check("arst_count", rdata, 32'd0);
    addr = StA;
    #1;
    check("arst_status", rdata, 32'h1);
    @(posedge clk); #1;
    addr = CycA;
    #1;
    check("arst_cycle", rdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_push_lost", 32'(tx_valid), 32'd0);
    load(SizeW, 32'h10, r);
    check("post_rst_ram_kept", r, 32'h8081_55F3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
